// File: rtl/pcileech_bar_initiator.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_bar_initiator
// Brief    : Command-driven BAR master issuing single writes, single reads and
//            read-poll-until-match toward a BAR responder, with tag checking
//            and a per-read timeout.
// Revision : 1.0  initial release
// ============================================================================
module pcileech_bar_initiator #(
    parameter int TIMEOUT  = 64,
    parameter int POLL_MAX = 16,
    parameter int POLL_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] base_address_register,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [10:0] cmd_offset,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    input  logic [31:0] cmd_expect,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    output logic [87:0] rd_req_ctx,
    output logic [31:0] rd_req_addr,
    output logic        rd_req_valid,
    input  logic [87:0] rd_rsp_ctx,
    input  logic [31:0] rd_rsp_data,
    input  logic        rd_rsp_valid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_status,
    output logic [31:0] res_data,
    output logic [7:0]  res_polls
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    localparam logic [2:0]  c_st_ok       = 3'd0;
    localparam logic [2:0]  c_st_timeout  = 3'd1;
    localparam logic [2:0]  c_st_poll_fail = 3'd2;
    localparam logic [2:0]  c_st_ctx_err  = 3'd3;
    localparam logic [2:0]  c_st_illegal  = 3'd4;
    localparam logic [1:0]  c_op_write    = 2'd0;
    localparam logic [1:0]  c_op_poll     = 2'd2;
    localparam logic [1:0]  c_op_illegal  = 2'd3;
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_gap_last    = (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);
    localparam logic [7:0]  c_poll_max    = 8'(POLL_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_data;
    logic [31:0] r_mask;
    logic [31:0] r_expect;
    logic [7:0]  r_tag;
    logic [7:0]  r_cur_tag;
    logic [31:0] r_cnt;
    logic [2:0]  r_status;
    logic [31:0] r_res_data;
    logic [7:0]  r_polls;

    logic w_rsp_hit;
    logic w_match;
    logic w_is_write;
    logic w_is_poll;
    logic w_timeout;
    logic w_poll_retry;

    assign w_rsp_hit    = (rd_rsp_ctx[87:8] == 80'h0) && (rd_rsp_ctx[7:0] == r_cur_tag);
    assign w_match      = ((rd_rsp_data ^ r_expect) & r_mask) == 32'h0;
    assign w_is_write   = (r_op == c_op_write);
    assign w_is_poll    = (r_op == c_op_poll);
    assign w_timeout    = (r_cnt == c_timeout_last);
    assign w_poll_retry = w_rsp_hit && w_is_poll && !w_match && (r_polls != c_poll_max);

    assign wr_addr     = r_addr;
    assign wr_be       = r_be;
    assign wr_data     = r_data;
    assign rd_req_addr = r_addr;
    assign rd_req_ctx  = {80'h0, r_tag};
    assign res_status  = r_status;
    assign res_data    = r_res_data;
    assign res_polls   = r_polls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        cmd_ready    = 1'b0;
        wr_valid     = 1'b0;
        rd_req_valid = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = (cmd_op == c_op_illegal) ? S_RESULT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_is_write) begin
                    wr_valid = 1'b1;
                    w_next   = S_RESULT;
                end else begin
                    rd_req_valid = 1'b1;
                    w_next       = S_WAIT;
                end
            end
            S_WAIT: begin
                // A reply arriving on the timeout cycle still wins.
                if (rd_rsp_valid) begin
                    w_next = w_poll_retry ? S_GAP : S_RESULT;
                end else if (w_timeout) begin
                    w_next = S_RESULT;
                end
            end
            S_GAP: begin
                if (r_cnt >= c_gap_last) begin
                    w_next = S_ISSUE;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 2'd0;
            r_addr     <= 32'h0;
            r_be       <= 4'h0;
            r_data     <= 32'h0;
            r_mask     <= 32'h0;
            r_expect   <= 32'h0;
            r_tag      <= 8'h0;
            r_cur_tag  <= 8'h0;
            r_cnt      <= 32'h0;
            r_status   <= c_st_ok;
            r_res_data <= 32'h0;
            r_polls    <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_addr     <= (base_address_register & ~32'h4) + {21'h0, cmd_offset};
                        r_be       <= cmd_be;
                        r_data     <= cmd_data;
                        r_mask     <= cmd_mask;
                        r_expect   <= cmd_expect;
                        r_polls    <= 8'h0;
                        r_res_data <= 32'h0;
                        r_status   <= (cmd_op == c_op_illegal) ? c_st_illegal : c_st_ok;
                    end
                end
                S_ISSUE: begin
                    if (!w_is_write) begin
                        r_cur_tag <= r_tag;
                        r_tag     <= r_tag + 8'd1;
                        r_polls   <= r_polls + 8'd1;
                        r_cnt     <= 32'h0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (rd_rsp_valid) begin
                        r_res_data <= rd_rsp_data;
                        r_cnt      <= 32'h0;
                        if (!w_rsp_hit) begin
                            r_status <= c_st_ctx_err;
                        end else if (w_is_poll && !w_match && (r_polls == c_poll_max)) begin
                            r_status <= c_st_poll_fail;
                        end else begin
                            r_status <= c_st_ok;
                        end
                    end else if (w_timeout) begin
                        r_status   <= c_st_timeout;
                        r_res_data <= 32'h0;
                    end
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pcileech_bar_initiator.md
Name: pcileech_bar_initiator

Overview:
- Command-driven master that generates BAR write and read requests toward a BAR implementation block, and consumes that block's read replies.
- Sits between a control source (self-test sequencer or debug shell) and any pcileech_bar_impl_* responder.
- Supports single write, single read and read-poll-until-match, with one read outstanding, tag matching via rd_req_ctx, and per-read timeout.

Parameters:
- TIMEOUT, 64: cycles allowed from read issue to reply before status TIMEOUT.
- POLL_MAX, 16: maximum reads per poll command, 1..255.
- POLL_GAP, 8: idle cycles between successive poll reads, 0..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- base_address_register  in  32  BAR base; issued address = (base & ~32'h4) + {21'h0, cmd_offset}
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0 = write, 1 = read, 2 = poll, 3 = reserved (returns status ILLEGAL)
- cmd_offset  in  11  byte offset in the 2 KB window
- cmd_be  in  4  write byte enables
- cmd_data  in  32  write data
- cmd_mask  in  32  poll mask
- cmd_expect  in  32  poll value; match when (rd_data & mask) == (expect & mask)
- wr_addr  out  32  BAR write address
- wr_be  out  4  BAR write byte enables
- wr_data  out  32  BAR write data
- wr_valid  out  1  one-cycle write strobe
- rd_req_ctx  out  88  {80'h0, tag[7:0]}
- rd_req_addr  out  32  BAR read address
- rd_req_valid  out  1  one-cycle read strobe
- rd_rsp_ctx  in  88  reply context
- rd_rsp_data  in  32  reply data
- rd_rsp_valid  in  1  reply strobe
- res_valid  out  1  result available, held until res_ready
- res_ready  in  1  result consumed
- res_status  out  3  0 OK, 1 TIMEOUT, 2 POLL_FAIL, 3 CTX_ERR, 4 ILLEGAL
- res_data  out  32  last read data; 0 for writes and illegal ops
- res_polls  out  8  number of reads issued by the command

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. Tag = 0. FSM = IDLE.
- FSM states: IDLE, ISSUE, WAIT, GAP, RESULT.
- IDLE:
  - cmd_ready = 1.
  - On accept, register all cmd_* fields and base_address_register, then go to ISSUE.
  - Op 3 goes directly to RESULT with status ILLEGAL.
- ISSUE (exactly one cycle):
  - Write: wr_valid = 1 with registered address, be and data; go to RESULT with status OK and res_polls = 0.
  - Read/poll: rd_req_valid = 1 with ctx tag = current tag; increment res_polls; clear the timeout counter; go to WAIT.
  - Tag increments after every issued read and wraps 255 -> 0.
- Strobe timing: wr_valid and rd_req_valid are never high for more than one cycle and never high together. cmd_ready = 0 in every state except IDLE.
- WAIT (timeout counter increments each cycle):
  - Reply with rd_rsp_ctx[7:0] == tag and rd_rsp_ctx[87:8] == 0: capture data.
    - Read: go to RESULT, status OK.
    - Poll with match: go to RESULT, status OK.
    - Poll with no match and res_polls < POLL_MAX: go to GAP.
    - Poll with no match and res_polls == POLL_MAX: go to RESULT, status POLL_FAIL.
  - Reply with any other ctx: go to RESULT, status CTX_ERR; res_data = the received data.
  - No reply and counter reaches TIMEOUT: go to RESULT, status TIMEOUT; res_data = 0.
  - A reply in the same cycle the counter reaches TIMEOUT takes priority over the timeout.
- GAP:
  - Wait POLL_GAP cycles, then go to ISSUE.
  - POLL_GAP = 0 goes to ISSUE on the next cycle.
- RESULT:
  - res_valid = 1 with stable outputs until res_ready is sampled high; then go to IDLE.
  - res_valid deasserts the cycle after the handshake.
  - Minimum command-to-command spacing is 3 cycles for writes.
- Stray replies: rd_rsp_valid in IDLE, ISSUE, GAP or RESULT is ignored (late replies after a timeout are discarded silently).
- Reset mid-operation: FSM returns to IDLE in the next cycle, strobes drop, the pending result is lost, and the tag resets to 0.
- Width rules: address sum is modulo 2^32; the offset is zero-extended.

Test Plan:
- Write: base 0xF7000004, write offset 0x050, data 0x00010000, be 0xF -> exactly one wr_valid pulse 1 cycle after accept with wr_addr 0xF7000050; res_status 0, res_data 0, res_polls 0.
- Read: read offset 0x020, responder returns 0xF000A222 two cycles after the request with echoed ctx -> rd_req_addr 0xF7000020, ctx 88'h00, result OK with data 0xF000A222 and res_polls 1; the next read uses tag 0x01.
- Poll success: poll offset 0x050, mask 0xFFFFFFFF, expect 0, responder returns 0x10000 then 0 -> two reads separated by GAP; status OK, res_polls 2, data 0.
- Poll fail: POLL_MAX 4, responder always returns 0x3F with expect 0 -> 4 reads, then status POLL_FAIL, data 0x3F.
- Timeout and ctx error: no responder reply -> status TIMEOUT exactly TIMEOUT+1 cycles after issue, and a late reply is ignored. Separately, a reply with tag+1 -> status CTX_ERR.
- Tag wrap, reset, and backpressure:
  - 256 reads -> tag wraps to 0.
  - Reset asserted during WAIT -> IDLE, cmd_ready = 1, and a subsequent reply is ignored.
  - res_ready held low for 10 cycles -> res_valid and all result fields remain stable.
